// File: rtl/latch_seq_pkg.sv
// rtl/latch_seq_pkg.sv - shared state encoding and counter sizing for latch_load_sequencer
package latch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    CLEAR  = 3'd4
  } state_t;

  // Wide enough to hold the longest phase length, so every N-1 load fits.
  function automatic int cnt_width(input int setup_cyc, input int strobe_cyc, input int hold_cyc);
    int m;
    m = setup_cyc;
    if (strobe_cyc > m) m = strobe_cyc;
    if (hold_cyc > m) m = hold_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - loadable down-counter with zero flag, saturating at 0
module phase_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic          zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/latch_load_sequencer.sv
// rtl/latch_load_sequencer.sv - setup/strobe/hold enable sequencer for a D-latch bank
// Optional latch clear path (clr_req, latch_reset_n, CLEAR state) under LATCH_CLR_EN.
module latch_load_sequencer
  import latch_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] d,
  output logic             enable,
  output logic             busy,
`ifdef LATCH_CLR_EN
  input  logic             clr_req,
  output logic             latch_reset_n,
`endif
  output logic             done
);

  localparam int CW = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_t           state, state_next;
  logic             cnt_load;
  logic [CW-1:0]    cnt_value;
  logic             cnt_zero;
  logic [WIDTH-1:0] d_next;
  logic             enable_next;
  logic             done_next;
`ifdef LATCH_CLR_EN
  logic             lrn_next;
`endif

  phase_counter #(.CW(CW)) u_phase_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      d      <= '0;
      enable <= 1'b0;
      done   <= 1'b0;
`ifdef LATCH_CLR_EN
      latch_reset_n <= 1'b1;
`endif
    end else begin
      state  <= state_next;
      d      <= d_next;
      enable <= enable_next;
      done   <= done_next;
`ifdef LATCH_CLR_EN
      latch_reset_n <= lrn_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_value  = '0;
    d_next     = d;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
`ifdef LATCH_CLR_EN
        if (clr_req) begin
          state_next = CLEAR;
          cnt_load   = 1'b1;
          cnt_value  = STROBE_LD;
          d_next     = '0;
        end else
`endif
        if (in_valid) begin
          state_next = SETUP;
          cnt_load   = 1'b1;
          cnt_value  = SETUP_LD;
          d_next     = in_data;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_next = STROBE;
          cnt_load   = 1'b1;
          cnt_value  = STROBE_LD;
        end
      end
      STROBE: begin
        if (cnt_zero) begin
          if (HOLD_CYC > 0) begin
            state_next = HOLD;
            cnt_load   = 1'b1;
            cnt_value  = HOLD_LD;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_zero) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Outputs are registered from the next state so they align with the phase.
    enable_next = (state_next == STROBE);
`ifdef LATCH_CLR_EN
    lrn_next = (state_next != CLEAR);
`endif
  end

  assign busy     = (state != IDLE);
  assign in_ready = (state == IDLE) && !reset;

endmodule

// File: tb/tb_latch_load_sequencer.sv
// tb/tb_latch_load_sequencer.sv - table-driven bench for latch_load_sequencer (LATCH_CLR_EN optional)
module tb_latch_load_sequencer;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic [7:0] exp_d;
    logic       exp_en;
    logic       exp_done;
    logic       exp_rdy;
    logic       exp_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, enable, busy, done;
  logic [7:0] d;
  logic       h0_valid = 1'b0;
  logic [7:0] h0_data = 8'h00;
  logic       h0_ready, h0_enable, h0_busy, h0_done;
  logic [7:0] h0_d;
`ifdef LATCH_CLR_EN
  logic       clr_req = 1'b0;
  logic       latch_reset_n;
  logic       h0_clr_req = 1'b0;
  logic       h0_latch_reset_n;
`endif

  int vectors = 0;
  int miscompares = 0;
  int stab_bad = 0;
  logic       prev_en = 1'b0;
  logic [7:0] prev_d = 8'h00;
  vec_t vecs[$];

  always #5 clk = ~clk;

  latch_load_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .d        (d),
    .enable   (enable),
    .busy     (busy),
`ifdef LATCH_CLR_EN
    .clr_req       (clr_req),
    .latch_reset_n (latch_reset_n),
`endif
    .done     (done)
  );

  latch_load_sequencer #(.HOLD_CYC(0)) dut_h0 (
    .clk      (clk),
    .reset    (reset),
    .in_valid (h0_valid),
    .in_data  (h0_data),
    .in_ready (h0_ready),
    .d        (h0_d),
    .enable   (h0_enable),
    .busy     (h0_busy),
`ifdef LATCH_CLR_EN
    .clr_req       (h0_clr_req),
    .latch_reset_n (h0_latch_reset_n),
`endif
    .done     (h0_done)
  );

  // d must never move while enable stays high
  always @(negedge clk) begin
    if (enable && prev_en && d !== prev_d) stab_bad <= stab_bad + 1;
    prev_en <= enable;
    prev_d  <= d;
  end

  task automatic chk8(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk1(input string name, input int idx, input logic act, input logic exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %b, want %b", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic [7:0] dat, input logic [7:0] ed,
                     input logic een, input logic edn, input logic erdy, input logic ebusy);
    vec_t t;
    t.rst = r; t.valid = v; t.data = dat; t.exp_d = ed;
    t.exp_en = een; t.exp_done = edn; t.exp_rdy = erdy; t.exp_busy = ebusy;
    vecs.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [0:4] h0_en_exp   = 5'b01100;
  logic [0:4] h0_done_exp = 5'b00010;
  logic [0:4] h0_rdy_exp  = 5'b00011;

  initial begin
    // reset state, then idle
    add(1, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    // single load 0xA5
    add(0, 1, 8'hA5, 8'hA5, 0, 0, 0, 1);
    add(0, 0, 8'h00, 8'hA5, 1, 0, 0, 1);
    add(0, 0, 8'h00, 8'hA5, 1, 0, 0, 1);
    add(0, 0, 8'h00, 8'hA5, 0, 0, 0, 1);
    add(0, 0, 8'h00, 8'hA5, 0, 1, 1, 0);
    add(0, 0, 8'h00, 8'hA5, 0, 0, 1, 0);
    // back-to-back 0x3C then 0xC3 held valid
    add(0, 1, 8'h3C, 8'h3C, 0, 0, 0, 1);
    add(0, 1, 8'hC3, 8'h3C, 1, 0, 0, 1);
    add(0, 1, 8'hC3, 8'h3C, 1, 0, 0, 1);
    add(0, 1, 8'hC3, 8'h3C, 0, 0, 0, 1);
    add(0, 1, 8'hC3, 8'h3C, 0, 1, 1, 0);
    add(0, 1, 8'hC3, 8'hC3, 0, 0, 0, 1);
    add(0, 0, 8'h00, 8'hC3, 1, 0, 0, 1);
    add(0, 0, 8'h00, 8'hC3, 1, 0, 0, 1);
    add(0, 0, 8'h00, 8'hC3, 0, 0, 0, 1);
    add(0, 0, 8'h00, 8'hC3, 0, 1, 1, 0);
    // busy ignore: 0xFF offered in HOLD
    add(0, 1, 8'hA5, 8'hA5, 0, 0, 0, 1);
    add(0, 0, 8'h00, 8'hA5, 1, 0, 0, 1);
    add(0, 0, 8'h00, 8'hA5, 1, 0, 0, 1);
    add(0, 1, 8'hFF, 8'hA5, 0, 0, 0, 1);
    add(0, 0, 8'h00, 8'hA5, 0, 1, 1, 0);
    add(0, 0, 8'h00, 8'hA5, 0, 0, 1, 0);
    // reset mid-strobe, then a clean transfer
    add(0, 1, 8'h5A, 8'h5A, 0, 0, 0, 1);
    add(0, 0, 8'h00, 8'h5A, 1, 0, 0, 1);
    add(1, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    add(0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    add(0, 1, 8'h96, 8'h96, 0, 0, 0, 1);
    add(0, 0, 8'h00, 8'h96, 1, 0, 0, 1);
    add(0, 0, 8'h00, 8'h96, 1, 0, 0, 1);
    add(0, 0, 8'h00, 8'h96, 0, 0, 0, 1);
    add(0, 0, 8'h00, 8'h96, 0, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset    = vecs[i].rst;
      in_valid = vecs[i].valid;
      in_data  = vecs[i].data;
      step();
      vectors++;
      chk8("d", i, d, vecs[i].exp_d);
      chk1("enable", i, enable, vecs[i].exp_en);
      chk1("done", i, done, vecs[i].exp_done);
      chk1("in_ready", i, in_ready, vecs[i].exp_rdy);
      chk1("busy", i, busy, vecs[i].exp_busy);
`ifdef LATCH_CLR_EN
      chk1("latch_reset_n", i, latch_reset_n, 1'b1);
`endif
    end
    reset    = 1'b0;
    in_valid = 1'b0;

    // HOLD_CYC=0 instance: done directly after the strobe
    for (int i = 0; i < 5; i++) begin
      h0_valid = (i == 0);
      h0_data  = (i == 0) ? 8'h77 : 8'h00;
      step();
      vectors++;
      chk8("h0_d", i, h0_d, 8'h77);
      chk1("h0_enable", i, h0_enable, h0_en_exp[i]);
      chk1("h0_done", i, h0_done, h0_done_exp[i]);
      chk1("h0_in_ready", i, h0_ready, h0_rdy_exp[i]);
    end
    h0_valid = 1'b0;

`ifdef LATCH_CLR_EN
    // clr_req wins over in_valid; word is not captured
    clr_req  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    step();
    vectors++;
    chk1("clr_lrn", 0, latch_reset_n, 1'b0);
    chk8("clr_d", 0, d, 8'h00);
    chk1("clr_enable", 0, enable, 1'b0);
    chk1("clr_done", 0, done, 1'b0);
    chk1("clr_busy", 0, busy, 1'b1);
    clr_req  = 1'b0;
    in_valid = 1'b0;
    step();
    vectors++;
    chk1("clr_lrn", 1, latch_reset_n, 1'b0);
    chk1("clr_enable", 1, enable, 1'b0);
    chk1("clr_done", 1, done, 1'b0);
    step();
    vectors++;
    chk1("clr_lrn", 2, latch_reset_n, 1'b1);
    chk1("clr_done", 2, done, 1'b1);
    chk1("clr_in_ready", 2, in_ready, 1'b1);
    chk8("clr_d", 2, d, 8'h00);
    step();
    vectors++;
    chk1("clr_done", 3, done, 1'b0);
    // reset during CLEAR releases latch_reset_n at that edge
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    reset   = 1'b1;
    step();
    vectors++;
    chk1("clr_rst_lrn", 0, latch_reset_n, 1'b1);
    chk1("clr_rst_done", 0, done, 1'b0);
    reset = 1'b0;
    step();
    vectors++;
    chk1("clr_rst_done", 1, done, 1'b0);
    chk1("clr_rst_busy", 1, busy, 1'b0);
`endif

    step();
    vectors++;
    if (stab_bad != 0) begin
      miscompares++;
      $display("FAIL d_stable: %0d changes of d while enable high, want 0", stab_bad);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
